skin_bbox: RTL and testbench
============================

Name: skin_bbox

Overview:
- Frame-statistics stage sitting directly downstream of the 5x5 median filter, in parallel with the centroid stage.
- Consumes the binary skin mask stream with its de/vsync timing.
- Tracks raster position and accumulates the bounding box and area of mask pixels over one frame.
- Publishes registered box coordinates plus a one-cycle valid pulse at each frame end, for overlay or tracking logic.

Parameters:
- X_W, 11, width of x coordinate/counter.
- Y_W, 11, width of y coordinate/counter.
- AREA_W, 22, width of the mask pixel area counter.
- MIN_AREA, 64, minimum pixel count for a frame's box to be reported as non-empty.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- ce  in  1  clock enable; all state registers update only when ce=1.
- de  in  1  data enable of the mask stream.
- vsync  in  1  vertical sync, active-high.
- mask  in  8  filtered mask; pixel is "skin" when mask != 0.
- x_min  out  X_W  leftmost skin column of last reported frame.
- x_max  out  X_W  rightmost skin column.
- y_min  out  Y_W  top skin row.
- y_max  out  Y_W  bottom skin row.
- area  out  AREA_W  skin pixel count of last completed frame.
- empty  out  1  1 when last completed frame had area < MIN_AREA.
- valid  out  1  one-cycle pulse when outputs refresh.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0 except empty=1.
  - Counters, accumulators and vs_d cleared.
  - FSM enters WAIT.
- Raster counters, ce=1 only:
  - x_cnt increments on each de=1 cycle; cleared on de=0.
  - y_cnt increments on the cycle de falls (de_d=1, de=0); cleared on vsync rising edge.
  - Both saturate at all-ones and never wrap.
- Frame edge: fe = ce & vsync & ~vs_d, where vs_d is vsync registered on ce.
- FSM:
  - WAIT: ignore pixels. On fe go to ACCUM and initialise the accumulators:
    - xmin/ymin = all-ones
    - xmax/ymax = 0
    - acc_area = 0
  - ACCUM, pixel with de=1 & mask!=0:
    - xmin=min(xmin,x_cnt), xmax=max(xmax,x_cnt).
    - ymin=min(ymin,y_cnt), ymax=max(ymax,y_cnt).
    - acc_area increments, saturating at all-ones.
  - ACCUM, on fe:
    - Latch area=acc_area; valid=1 next cycle.
    - If acc_area >= MIN_AREA: empty=0 and the box outputs take the accumulated values.
    - Otherwise: empty=1 and the box outputs hold their previous values.
    - Re-initialise the accumulators; stay in ACCUM.
- Latency: outputs and valid are registered on the clock edge of the fe cycle.
  - Visible one cycle after the vsync rising edge is sampled.
  - valid is high for exactly one clock, then 0.
- Simultaneous events: a skin pixel with de=1 in the fe cycle is counted into the closing frame before latching.
- ce=0:
  - Every register holds, including vs_d and the FSM.
  - valid is forced 0 during ce=0 cycles; a pending pulse occurs only in a ce=1 cycle.
- Reset mid-frame: the partial frame is discarded. The first frame after reset is never reported (WAIT), so the first valid follows the second vsync edge.
- Box invariant when empty=0: x_min<=x_max and y_min<=y_max.

Decomposition:
- Shared package/include holds:
  - X_W/Y_W/AREA_W defaults.
  - MIN_AREA default.
  - FSM state encodings WAIT=0, ACCUM=1.
- One natural sub-module: raster_pos, containing de/vsync edge detection plus x_cnt/y_cnt with saturation.
  - Outputs x, y and fe.
  - Reusable by the centroid and visualize stages.

Test Plan:
- Reset, two vsync pulses, a 64x48 frame containing an 8x8 skin square at columns 10..17, rows 5..12 -> after the second vsync edge: x_min=10, x_max=17, y_min=5, y_max=12, area=64, empty=0, valid high one cycle.
- Next frame all-zero mask -> valid pulse, area=0, empty=1, box holds 10/17/5/12.
- Frame containing a single skin pixel at (63,47) with MIN_AREA=1 -> box 63/63/47/47, area=1, empty=0.
- Assert rst mid-frame during the square region, then run one full frame -> no valid for that frame; the first valid appears after the second post-reset vsync edge.
- Same square frame with ce toggling 1,0 every cycle (stream held during ce=0) -> identical box and area; valid asserted only in a ce=1 cycle.
- Skin pixel with de=1 coincident with the vsync rising edge at (20,30) -> included in the closing frame: x_max>=20, area incremented by 1.

Source files
------------

// File: rtl/skin_bbox_pkg.sv
// Shared widths, report threshold and FSM encoding for the skin-mask frame statistics stages.
package skin_bbox_pkg;
  localparam int X_W_DEF      = 11;
  localparam int Y_W_DEF      = 11;
  localparam int AREA_W_DEF   = 22;
  localparam int MIN_AREA_DEF = 64;

  typedef enum logic {
    WAIT  = 1'b0,
    ACCUM = 1'b1
  } state_t;
endpackage

// File: rtl/skin_bbox_raster_pos.sv
// Raster position tracker: saturating column/row counters plus the vsync frame-edge strobe.
module raster_pos
  import skin_bbox_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           de,
  input  logic           vsync,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           fe
);
  logic de_d, vs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      de_d <= 1'b0;
      vs_d <= 1'b0;
    end else if (ce) begin
      de_d <= de;
      vs_d <= vsync;
      if (!de)           x <= '0;
      else if (x != '1) x <= x + X_W'(1);
      // a vsync edge wins over a coincident line end so each frame starts at row 0
      if (vsync && !vs_d)                  y <= '0;
      else if (de_d && !de && (y != '1))   y <= y + Y_W'(1);
    end
  end

  assign fe = ce & vsync & ~vs_d;
endmodule

// File: rtl/skin_bbox.sv
// Per-frame bounding box and area of non-zero mask pixels, published with a valid pulse at frame end.
module skin_bbox
  import skin_bbox_pkg::*;
#(
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int AREA_W   = AREA_W_DEF,
  parameter int MIN_AREA = MIN_AREA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              de,
  input  logic              vsync,
  input  logic [7:0]        mask,
  output logic [X_W-1:0]    x_min,
  output logic [X_W-1:0]    x_max,
  output logic [Y_W-1:0]    y_min,
  output logic [Y_W-1:0]    y_max,
  output logic [AREA_W-1:0] area,
  output logic              empty,
  output logic              valid
);
  logic [X_W-1:0]    x, xmin, xmax, n_xmin, n_xmax;
  logic [Y_W-1:0]    y, ymin, ymax, n_ymin, n_ymax;
  logic [AREA_W-1:0] acc_area, n_area;
  logic              fe, skin, valid_q;
  state_t            state;

  raster_pos #(.X_W(X_W), .Y_W(Y_W)) u_pos (
    .clk(clk), .rst(rst), .ce(ce), .de(de), .vsync(vsync),
    .x(x), .y(y), .fe(fe)
  );

  assign skin = (state == ACCUM) && de && (mask != 8'd0);

  // next accumulator values including the current pixel, so a pixel on the fe cycle closes its frame
  always_comb begin
    n_xmin = xmin;
    n_xmax = xmax;
    n_ymin = ymin;
    n_ymax = ymax;
    n_area = acc_area;
    if (skin) begin
      if (x < xmin) n_xmin = x;
      if (x > xmax) n_xmax = x;
      if (y < ymin) n_ymin = y;
      if (y > ymax) n_ymax = y;
      if (acc_area != '1) n_area = acc_area + AREA_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT;
      xmin     <= '0;
      xmax     <= '0;
      ymin     <= '0;
      ymax     <= '0;
      acc_area <= '0;
      x_min    <= '0;
      x_max    <= '0;
      y_min    <= '0;
      y_max    <= '0;
      area     <= '0;
      empty    <= 1'b1;
      valid_q  <= 1'b0;
    end else if (ce) begin
      valid_q <= 1'b0;
      if (fe) begin
        if (state == ACCUM) begin
          area    <= n_area;
          valid_q <= 1'b1;
          if (n_area >= AREA_W'(MIN_AREA)) begin
            empty <= 1'b0;
            x_min <= n_xmin;
            x_max <= n_xmax;
            y_min <= n_ymin;
            y_max <= n_ymax;
          end else begin
            empty <= 1'b1;
          end
        end
        state    <= ACCUM;
        xmin     <= '1;
        xmax     <= '0;
        ymin     <= '1;
        ymax     <= '0;
        acc_area <= '0;
      end else begin
        xmin     <= n_xmin;
        xmax     <= n_xmax;
        ymin     <= n_ymin;
        ymax     <= n_ymax;
        acc_area <= n_area;
      end
    end
  end

  // the pulse register holds through ce=0 and only shows in an enabled cycle
  assign valid = valid_q & ce;
endmodule

// File: tb/tb_skin_bbox.sv
// Self-checking bench for skin_bbox: two instances (MIN_AREA 64 and 1) against a frame-level model.
module tb_skin_bbox;
  logic        clk = 1'b0;
  logic        rst, ce, de, vsync;
  logic [7:0]  mask;
  logic [10:0] x_min0, x_max0, y_min0, y_max0, x_min1, x_max1, y_min1, y_max1;
  logic [21:0] area0, area1;
  logic        empty0, empty1, valid0, valid1;

  skin_bbox dut0 (
    .clk(clk), .rst(rst), .ce(ce), .de(de), .vsync(vsync), .mask(mask),
    .x_min(x_min0), .x_max(x_max0), .y_min(y_min0), .y_max(y_max0),
    .area(area0), .empty(empty0), .valid(valid0)
  );
  skin_bbox #(.MIN_AREA(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .de(de), .vsync(vsync), .mask(mask),
    .x_min(x_min1), .x_max(x_max1), .y_min(y_min1), .y_max(y_max1),
    .area(area1), .empty(empty1), .valid(valid1)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0;
  int vc0 = 0, vc1 = 0, vce0 = 0;
  bit ce_toggle = 1'b0;

  // frame-level reference: skin pixel statistics of the frame being driven
  int f_cnt, f_xmin, f_xmax, f_ymin, f_ymax;
  bit armed = 1'b0;
  logic [43:0] eb0 = '0, eb1 = '0;
  int ea0 = 0, ea1 = 0, ev = 0;
  bit ee0 = 1'b1, ee1 = 1'b1;

  always @(negedge clk) begin
    if (valid0) vc0++;
    if (valid1) vc1++;
    if ((valid0 || valid1) && !ce) vce0++;
  end

  function automatic void clear_stats();
    f_cnt = 0; f_xmin = 1 << 30; f_xmax = -1; f_ymin = 1 << 30; f_ymax = -1;
  endfunction

  function automatic void note_pixel(input int px, input int py);
    f_cnt++;
    if (px < f_xmin) f_xmin = px;
    if (px > f_xmax) f_xmax = px;
    if (py < f_ymin) f_ymin = py;
    if (py > f_ymax) f_ymax = py;
  endfunction

  task automatic step(input logic d, input logic v, input logic [7:0] m);
    @(posedge clk); #2;
    de = d; vsync = v; mask = m; ce = 1'b1;
    if (ce_toggle) begin
      @(posedge clk); #2;
      ce = 1'b0;
    end
  endtask

  // kind 0: 8x8 square at cols 10..17 rows 5..12, 1: blank, 2: pixel (63,47), else random density pct
  task automatic lines(input int w, input int h, input int kind, input int pct, input int abort_row);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        bit on;
        case (kind)
          0:       on = (xx >= 10 && xx <= 17 && yy >= 5 && yy <= 12);
          1:       on = 1'b0;
          2:       on = (xx == 63 && yy == 47);
          default: on = ($urandom_range(0, 99) < pct);
        endcase
        if (yy == abort_row && xx == 12) begin
          @(posedge clk); #2; rst = 1'b1;
          repeat (2) @(posedge clk);
          #2; rst = 1'b0;
          armed = 1'b0; clear_stats();
          eb0 = '0; eb1 = '0; ea0 = 0; ea1 = 0; ee0 = 1'b1; ee1 = 1'b1;
          return;
        end
        if (on) note_pixel(xx, yy);
        step(1'b1, 1'b0, on ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 8'h00);
    end
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic close_frame(input bit px, input int cx, input int cy);
    if (px) note_pixel(cx, cy);
    step(px, 1'b1, px ? 8'h5a : 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    if (armed) begin
      ev = 1; ea0 = f_cnt; ea1 = f_cnt;
      if (f_cnt >= 64) begin
        ee0 = 1'b0; eb0 = {11'(f_xmin), 11'(f_xmax), 11'(f_ymin), 11'(f_ymax)};
      end else ee0 = 1'b1;
      if (f_cnt >= 1) begin
        ee1 = 1'b0; eb1 = {11'(f_xmin), 11'(f_xmax), 11'(f_ymin), 11'(f_ymax)};
      end else ee1 = 1'b1;
    end else ev = 0;
    armed = 1'b1;
    clear_stats();
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; de = 1'b0; vsync = 1'b0; mask = 8'h00;
    clear_stats();
    #1;
    ncmp++; if ({x_min0, x_max0, y_min0, y_max0} !== 44'd0) begin nerr++; $display("FAIL rst_box got %h exp 0", {x_min0, x_max0, y_min0, y_max0}); end
    ncmp++; if (area0 !== 22'd0) begin nerr++; $display("FAIL rst_area got %0d exp 0", area0); end
    ncmp++; if ({empty0, empty1} !== 2'b11) begin nerr++; $display("FAIL rst_empty got %b exp 11", {empty0, empty1}); end
    ncmp++; if ({valid0, valid1} !== 2'b00) begin nerr++; $display("FAIL rst_valid got %b exp 00", {valid0, valid1}); end
    @(posedge clk); #2; rst = 1'b0;
  endtask

  task automatic test_square();
    int b0, b1;
    b0 = vc0; b1 = vc1;
    close_frame(1'b0, 0, 0);
    ncmp++; if ((vc0 - b0) !== 0 || (vc1 - b1) !== 0) begin nerr++; $display("FAIL first_edge_valid got %0d/%0d exp 0", vc0 - b0, vc1 - b1); end
    b0 = vc0; b1 = vc1;
    lines(64, 48, 0, 0, -1);
    close_frame(1'b0, 0, 0);
    ncmp++; if ((vc0 - b0) !== ev) begin nerr++; $display("FAIL sq_valid0 got %0d exp %0d", vc0 - b0, ev); end
    ncmp++; if ((vc1 - b1) !== ev) begin nerr++; $display("FAIL sq_valid1 got %0d exp %0d", vc1 - b1, ev); end
    ncmp++; if ({x_min0, x_max0, y_min0, y_max0} !== eb0) begin nerr++; $display("FAIL sq_box0 got %h exp %h", {x_min0, x_max0, y_min0, y_max0}, eb0); end
    ncmp++; if ({x_min1, x_max1, y_min1, y_max1} !== eb1) begin nerr++; $display("FAIL sq_box1 got %h exp %h", {x_min1, x_max1, y_min1, y_max1}, eb1); end
    ncmp++; if (area0 !== 22'(ea0) || area1 !== 22'(ea1)) begin nerr++; $display("FAIL sq_area got %0d/%0d exp %0d", area0, area1, ea0); end
    ncmp++; if ({empty0, empty1} !== {ee0, ee1}) begin nerr++; $display("FAIL sq_empty got %b exp %b", {empty0, empty1}, {ee0, ee1}); end
  endtask

  task automatic test_blank_and_single();
    int b0, b1;
    for (int k = 0; k < 2; k++) begin
      b0 = vc0; b1 = vc1;
      lines(64, 48, (k == 0) ? 1 : 2, 0, -1);
      close_frame(1'b0, 0, 0);
      ncmp++; if ((vc0 - b0) !== ev || (vc1 - b1) !== ev) begin nerr++; $display("FAIL bs%0d_valid got %0d/%0d exp %0d", k, vc0 - b0, vc1 - b1, ev); end
      ncmp++; if ({x_min0, x_max0, y_min0, y_max0} !== eb0) begin nerr++; $display("FAIL bs%0d_box0 got %h exp %h", k, {x_min0, x_max0, y_min0, y_max0}, eb0); end
      ncmp++; if ({x_min1, x_max1, y_min1, y_max1} !== eb1) begin nerr++; $display("FAIL bs%0d_box1 got %h exp %h", k, {x_min1, x_max1, y_min1, y_max1}, eb1); end
      ncmp++; if (area0 !== 22'(ea0) || area1 !== 22'(ea1)) begin nerr++; $display("FAIL bs%0d_area got %0d/%0d exp %0d", k, area0, area1, ea0); end
      ncmp++; if ({empty0, empty1} !== {ee0, ee1}) begin nerr++; $display("FAIL bs%0d_empty got %b exp %b", k, {empty0, empty1}, {ee0, ee1}); end
    end
  endtask

  task automatic test_ce_toggle();
    int b0, bc;
    b0 = vc0; bc = vce0;
    ce_toggle = 1'b1;
    lines(64, 48, 0, 0, -1);
    close_frame(1'b0, 0, 0);
    ce_toggle = 1'b0;
    ncmp++; if ((vc0 - b0) !== ev) begin nerr++; $display("FAIL ce_valid got %0d exp %0d", vc0 - b0, ev); end
    ncmp++; if ((vce0 - bc) !== 0) begin nerr++; $display("FAIL ce_valid_in_ce0 got %0d exp 0", vce0 - bc); end
    ncmp++; if ({x_min0, x_max0, y_min0, y_max0} !== eb0) begin nerr++; $display("FAIL ce_box0 got %h exp %h", {x_min0, x_max0, y_min0, y_max0}, eb0); end
    ncmp++; if (area0 !== 22'(ea0) || empty0 !== ee0) begin nerr++; $display("FAIL ce_area got %0d/%b exp %0d/%b", area0, empty0, ea0, ee0); end
  endtask

  task automatic test_reset_mid();
    int b0, b1;
    for (int k = 0; k < 2; k++) begin
      b0 = vc0; b1 = vc1;
      lines(64, 48, 0, 0, (k == 0) ? 8 : -1);
      close_frame(1'b0, 0, 0);
      ncmp++; if ((vc0 - b0) !== ev || (vc1 - b1) !== ev) begin nerr++; $display("FAIL rm%0d_valid got %0d/%0d exp %0d", k, vc0 - b0, vc1 - b1, ev); end
      ncmp++; if ({x_min0, x_max0, y_min0, y_max0} !== eb0) begin nerr++; $display("FAIL rm%0d_box0 got %h exp %h", k, {x_min0, x_max0, y_min0, y_max0}, eb0); end
      ncmp++; if (area0 !== 22'(ea0) || empty0 !== ee0) begin nerr++; $display("FAIL rm%0d_area got %0d/%b exp %0d/%b", k, area0, empty0, ea0, ee0); end
    end
  endtask

  task automatic test_random();
    int b0, b1, bc;
    for (int k = 0; k < 5; k++) begin
      b0 = vc0; b1 = vc1; bc = vce0;
      ce_toggle = 1'($urandom_range(0, 1));
      lines(24, 16, 3, $urandom_range(0, 40), -1);
      close_frame(1'b0, 0, 0);
      ce_toggle = 1'b0;
      ncmp++; if ((vc0 - b0) !== ev || (vc1 - b1) !== ev || (vce0 - bc) !== 0) begin nerr++; $display("FAIL rnd%0d_valid got %0d/%0d/%0d exp %0d", k, vc0 - b0, vc1 - b1, vce0 - bc, ev); end
      ncmp++; if ({x_min0, x_max0, y_min0, y_max0} !== eb0) begin nerr++; $display("FAIL rnd%0d_box0 got %h exp %h", k, {x_min0, x_max0, y_min0, y_max0}, eb0); end
      ncmp++; if ({x_min1, x_max1, y_min1, y_max1} !== eb1) begin nerr++; $display("FAIL rnd%0d_box1 got %h exp %h", k, {x_min1, x_max1, y_min1, y_max1}, eb1); end
      ncmp++; if (area0 !== 22'(ea0) || area1 !== 22'(ea1)) begin nerr++; $display("FAIL rnd%0d_area got %0d/%0d exp %0d", k, area0, area1, ea0); end
      ncmp++; if ({empty0, empty1} !== {ee0, ee1}) begin nerr++; $display("FAIL rnd%0d_empty got %b exp %b", k, {empty0, empty1}, {ee0, ee1}); end
    end
  endtask

  // square in rows 0..29, then row 30 carries one skin pixel at column 20 on the vsync edge
  task automatic test_coincident();
    int b0;
    b0 = vc0;
    lines(64, 30, 0, 0, -1);
    for (int xx = 0; xx < 20; xx++) step(1'b1, 1'b0, 8'h00);
    close_frame(1'b1, 20, 30);
    ncmp++; if ((vc0 - b0) !== ev) begin nerr++; $display("FAIL co_valid got %0d exp %0d", vc0 - b0, ev); end
    ncmp++; if ({x_min0, x_max0, y_min0, y_max0} !== eb0) begin nerr++; $display("FAIL co_box0 got %h exp %h", {x_min0, x_max0, y_min0, y_max0}, eb0); end
    ncmp++; if ({x_min1, x_max1, y_min1, y_max1} !== eb1) begin nerr++; $display("FAIL co_box1 got %h exp %h", {x_min1, x_max1, y_min1, y_max1}, eb1); end
    ncmp++; if (area0 !== 22'(ea0) || empty0 !== ee0) begin nerr++; $display("FAIL co_area got %0d/%b exp %0d/%b", area0, empty0, ea0, ee0); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_blank_and_single();
    test_ce_toggle();
    test_reset_mid();
    test_random();
    test_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
